// File: rtl/accum_ctrl.sv
// accum_ctrl: streams len operands through an external adder and accumulates
// them into a registered sum, with a sticky unsigned-overflow flag.
// Jobs can be cancelled with abort. done pulses once per completed job.
module accum_ctrl #(
  parameter int WIDTH = 32,
  parameter int LENW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  input  logic             abort,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LENW-1:0] cnt;
  logic            beat;

  // Abort blocks the stream in the same cycle, so a coincident beat is never taken.
  assign din_ready = (state == ACC) && !abort;
  assign beat      = din_ready && din_valid;

  // The external adder always sees accumulator + current operand.
  assign add_a = sum;
  assign add_b = din;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (beat && (cnt == LENW'(1))) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ACC;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, accumulator and overflow flag; hold whenever no beat or control event occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
      ovf <= 1'b0;
    end else if ((state == IDLE) && start) begin
      cnt <= len;
      sum <= '0;
      ovf <= 1'b0;
    end else if ((state == ACC) && abort) begin
      cnt <= '0;
      sum <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      cnt <= cnt - LENW'(1);
      sum <= add_s;
      ovf <= ovf | add_c;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench for accum_ctrl: each job pushes its expected final
// sum/ovf; a monitor pops and compares whenever done pulses.
module tb_accum_ctrl;

  localparam int WIDTH = 32;
  localparam int LENW  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LENW-1:0]  len = '0;
  logic             abort = 1'b0;
  logic             din_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH:0]   full;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  // Behavioral external adder.
  assign full  = {1'b0, add_a} + {1'b0, add_b};
  assign add_s = full[WIDTH-1:0];
  assign add_c = full[WIDTH];

  accum_ctrl #(.WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .busy(busy), .done(done), .sum(sum), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare against the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_sum", 64'(sum), 64'(e.s));
        chk("done_ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  task automatic go(input logic [LENW-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    din_valid = 1'b1;
    din       = d;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int dc;
    exp_t e;

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ready", 64'(din_ready), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_ovf", 64'(ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);

    // Basic job: 5+7+9
    e.s = 21; e.o = 0; exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    busy_cnt = 0;
    go(3);
    beat(5); beat(7); beat(9);
    @(negedge clk);
    chk("basic_done_timing", 64'(done), 1);
    idle_cycles(2);
    chk("basic_busy_cycles", 64'(busy_cnt), 4);
    chk("basic_sum_hold", 64'(sum), 21);

    // Stalled stream: 1, gap of 3, 2
    e.s = 3; e.o = 0; exp_q.push_back(e);
    go(2);
    beat(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sum_hold", 64'(sum), 1);
      chk("stall_busy", 64'(busy), 1);
      @(posedge clk); #1;
    end
    beat(2);
    @(negedge clk);
    chk("stall_done_timing", 64'(done), 1);
    idle_cycles(2);

    // Overflow, then a clean job clears ovf
    e.s = 32'h0000_0001; e.o = 1; exp_q.push_back(e);
    go(2);
    beat(32'hFFFF_FFFF); beat(32'h0000_0002);
    idle_cycles(2);
    chk("ovf_hold_idle", 64'(ovf), 1);
    e.s = 4; e.o = 0; exp_q.push_back(e);
    go(1);
    @(negedge clk);
    chk("ovf_cleared_on_start", 64'(ovf), 0);
    chk("sum_cleared_on_start", 64'(sum), 0);
    @(posedge clk); #1;
    beat(4);
    idle_cycles(2);

    // Zero length, with abort held (ignored in IDLE/DONE) and din_valid high
    e.s = 0; e.o = 0; exp_q.push_back(e);
    abort = 1'b1;
    din_valid = 1'b1;
    din = 32'h55;
    go(0);
    @(negedge clk);
    chk("zero_done", 64'(done), 1);
    chk("zero_ready", 64'(din_ready), 0);
    chk("zero_sum", 64'(sum), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_ready_after", 64'(din_ready), 0);
    chk("zero_idle", 64'(busy), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    din_valid = 1'b0;
    idle_cycles(1);

    // Abort after 2 of 4 beats, coincident with a valid beat
    dc = done_cnt;
    go(4);
    beat(10); beat(20);
    abort = 1'b1;
    din_valid = 1'b1;
    din = 99;
    @(negedge clk);
    chk("abort_ready_low", 64'(din_ready), 0);
    chk("abort_sum_before", 64'(sum), 30);
    @(posedge clk); #1;
    abort = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 0);
    chk("abort_sum", 64'(sum), 0);
    chk("abort_ovf", 64'(ovf), 0);
    idle_cycles(3);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));

    // start ignored in ACC and DONE
    e.s = 7; e.o = 0; exp_q.push_back(e);
    go(2);
    start = 1'b1;
    len = 0;
    beat(3); beat(4);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("nostart_idle", 64'(busy), 0);
    chk("nostart_sum", 64'(sum), 7);
    idle_cycles(2);

    // Reset mid-job
    go(3);
    beat(1);
    din_valid = 1'b1;
    din = 5;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_ready", 64'(din_ready), 0);
    chk("mid_rst_sum", 64'(sum), 0);
    chk("mid_rst_done", 64'(done), 0);
    chk("mid_rst_ovf", 64'(ovf), 0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wait", 64'(busy), 0);
    @(posedge clk); #1;
    e.s = 6; e.o = 0; exp_q.push_back(e);
    go(1);
    @(negedge clk);
    chk("post_rst_start", 64'(busy), 1);
    @(posedge clk); #1;
    beat(6);
    idle_cycles(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
